// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM states and byte-lane helper for the MIPS32 data memory.
package data_memory_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Big-endian lanes: bit 3 of the mask enables [31:24] (byte offset 0).
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_B:  m = 4'b1000 >> offset;
      SIZE_H:  m = offset[1] ? 4'b0011 : 4'b1100;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between the load/store stage (master) and the data memory (slave).
// Handshake: a request is taken on a rising edge where req=1 and ready=1; req while ready=0 is
// ignored. The response is a single-cycle done pulse, with rdata and err valid in that cycle.
interface data_memory_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, size, sign_ext, addr, wdata,
                  input  ready, done, rdata, err);
  modport slave  (input  req, we, size, sign_ext, addr, wdata,
                  output ready, done, rdata, err);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: replicate store data across lanes with a byte-enable mask,
// and extract/extend the addressed byte or halfword of a loaded word.
module mem_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wword,
  output logic [3:0]  be,
  output logic [31:0] rdata
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign be = lane_mask(size, offset);

  always_comb begin
    wword = wdata;
    case (size)
      SIZE_B:  wword = {4{wdata[7:0]}};
      SIZE_H:  wword = {2{wdata[15:0]}};
      default: wword = wdata;
    endcase
  end

  always_comb begin
    sel_b = rword[31:24];
    case (offset)
      2'd0:    sel_b = rword[31:24];
      2'd1:    sel_b = rword[23:16];
      2'd2:    sel_b = rword[15:8];
      default: sel_b = rword[7:0];
    endcase
    sel_h = offset[1] ? rword[15:0] : rword[31:16];
    case (size)
      SIZE_B:  rdata = {{24{sign_ext & sel_b[7]}}, sel_b};
      SIZE_H:  rdata = {{16{sign_ext & sel_h[15]}}, sel_h};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with wait states, sub-word access and error flagging.
// The array access happens on the edge entering RESP; errors skip WAIT and never touch the array.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_memory_if.slave   bus,
  output state_t         fsm_state
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            access, chk_err;
  logic            we_q, sign_q, err_q;
  logic [1:0]      size_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q, rdata_q;

  logic            a_we, a_sign;
  logic [1:0]      a_size;
  logic [AW+1:0]   a_addr;
  logic [31:0]     a_wdata;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     wword, rd_ext;
  logic [3:0]      be;

  always_comb begin
    chk_err = (bus.addr >> (AW + 2)) != 32'd0;
    case (bus.size)
      SIZE_B:  ;
      SIZE_H:  if (bus.addr[0]) chk_err = 1'b1;
      SIZE_W:  if (bus.addr[1:0] != 2'b00) chk_err = 1'b1;
      default: chk_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (chk_err) begin
            state_nx = RESP;
          end else if (WAIT_STATES == 0) begin
            state_nx = RESP;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          access   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero wait states the access coincides with acceptance, so operands come straight off the bus.
  always_comb begin
    if (state == IDLE) begin
      a_we    = bus.we;
      a_sign  = bus.sign_ext;
      a_size  = bus.size;
      a_addr  = bus.addr[AW+1:0];
      a_wdata = bus.wdata;
    end else begin
      a_we    = we_q;
      a_sign  = sign_q;
      a_size  = size_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && bus.req) begin
        we_q    <= bus.we;
        sign_q  <= bus.sign_ext;
        size_q  <= bus.size;
        addr_q  <= bus.addr[AW+1:0];
        wdata_q <= bus.wdata;
        err_q   <= chk_err;
      end
      if (access && !a_we) rdata_q <= rd_ext;
    end
  end

  mem_lane_align u_align (
    .size     (a_size),
    .offset   (a_addr[1:0]),
    .sign_ext (a_sign),
    .wdata    (a_wdata),
    .rword    (mem[a_addr[AW+1:2]]),
    .wword    (wword),
    .be       (be),
    .rdata    (rd_ext)
  );

  // Gated by rst_n so a request seen during reset can never write.
  always_ff @(posedge clk) begin
    if (access && a_we && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[a_addr[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == RESP);
  assign bus.err   = (state == RESP) && err_q;
  assign bus.rdata = rdata_q;
  assign fsm_state = state;

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the MIPS32 datapath, with a request/response handshake. It is parametrised in depth and wait-state latency. It supports byte, halfword and word loads and stores (loads sign- or zero-extended), and flags misaligned or out-of-range accesses instead of performing them. It sits between the load/store stage and the data storage array, and lets the core stall on `ready`/`done` rather than assume a combinational access.

## Interface
Parameters:
- `DEPTH`, 1024, number of 32-bit words; power of two, ≥ 4
- `WAIT_STATES`, 1, extra cycles between acceptance and response; 0–15

Ports:
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, asynchronous, active-low reset
- `req` in 1, request valid; sampled only while `ready`=1
- `we` in 1, 1 = store, 0 = load
- `size` in 2, access size: 00 byte, 01 halfword, 10 word, 11 illegal
- `sign_ext` in 1, loads only: 1 sign-extends, 0 zero-extends
- `addr` in 32, byte address
- `wdata` in 32, store data; right-aligned (byte in [7:0], halfword in [15:0])
- `ready` out 1, block idle and able to accept a request
- `done` out 1, one-cycle response pulse
- `rdata` out 32, load result, right-aligned and extended
- `err` out 1, valid with `done`: misaligned access, illegal size, or `addr` ≥ 4·`DEPTH`

## Operation
- FSM states: IDLE, WAIT, RESP.
- Reset values: state=IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, wait counter=0. Array contents are not reset.
- IDLE: `ready`=1. When `req`=1, latch `we`, `size`, `sign_ext`, `addr`, `wdata` and run the error check.
  - Error detected: go to RESP with `err`=1. Nothing is written and `rdata` holds its previous value.
  - Otherwise, if `WAIT_STATES`=0, go to RESP; else load the counter with `WAIT_STATES`-1 and go to WAIT.
- WAIT: `ready`=0. Decrement the counter; at 0, go to RESP.
- The array access happens on the clock edge entering RESP:
  - Store: writes only the selected byte lanes of word `addr[AW+1:2]`, where AW = log2(DEPTH).
  - Load: registers the extracted, extended value into `rdata`.
- RESP: `done`=1 and `ready`=0 for exactly one cycle, then IDLE. `err` is asserted only in RESP.
- Byte order is big-endian: offset 0 maps to [31:24], offset 3 to [7:0]; halfword offset 0 maps to [31:16], offset 2 to [15:0].
- Alignment rules: a halfword needs `addr[0]`=0; a word needs `addr[1:0]`=00.
- `req` while `ready`=0 is ignored; it is neither queued nor an error.
- `rdata` changes only on a successful load.
- `rst_n` low mid-operation: return to IDLE immediately. A pending store is aborted and never written.

## Timing
- Acceptance edge is cycle 0. `done` is high in cycle `WAIT_STATES`+1, and `rdata`/`err` are valid in that same cycle.
- Error responses always arrive in cycle 1, regardless of `WAIT_STATES`.
- Peak throughput is one access per `WAIT_STATES`+2 cycles. `ready` rises the cycle after `done`.
- A store is visible to a load accepted after its `done`.

## Structure
- Package `data_memory_pkg`:
  - size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`
  - FSM state enum
  - byte-lane mask function (size, offset → 4-bit enable)
- Sub-module `mem_lane_align` (combinational):
  - store path: replicates `wdata` to lanes and produces the byte-enable mask
  - load path: extracts and extends the selected lanes
- The FSM, counter and array stay in `data_memory`.

## Test plan
- Reset then word store: store 0x11223344 at 0x10, then load word from 0x10 → `rdata`=0x11223344, `err`=0, and `done` lands exactly in cycle `WAIT_STATES`+1.
- Sub-word loads from word 0x80F0_0FFF at 0x20:
  - `lb` at 0x20 → 0xFFFFFF80
  - `lbu` at 0x20 → 0x00000080
  - `lh` at 0x22 → 0x00000FFF
  - `lhu` at 0x20 → 0x000080F0
- Byte-lane store: write 0xAABBCCDD at 0x40, then `sb` 0x5A at 0x41 → word reads 0xAA5ACCDD.
- Error cases, each giving `done`+`err` in cycle 1 with the array and `rdata` unchanged:
  - word at 0x42
  - halfword at 0x43
  - `size`=11
  - `addr`=4·`DEPTH`
- Handshake: `req` held high through a busy access → exactly one response, and `ready`=0 from cycle 1 through the `done` cycle.
- Reset mid-store: store 0x12345678 at 0x80 with `rst_n` pulsed low during WAIT → after reset, a load from 0x80 returns the prior contents.
